// File: rtl/execute_stage_pkg.sv
// Shared encodings for the MIPS execute stage: ALU operation codes,
// multiply/divide operation codes and the multiply/divide FSM states.
package execute_stage_pkg;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SLTU = 4'b1001;
    localparam logic [3:0] ALU_LUI  = 4'b1010;
    localparam logic [3:0] ALU_NOR  = 4'b1100;

    localparam logic [2:0] MD_NONE  = 3'b000;
    localparam logic [2:0] MD_MULT  = 3'b001;
    localparam logic [2:0] MD_MULTU = 3'b010;
    localparam logic [2:0] MD_DIV   = 3'b011;
    localparam logic [2:0] MD_DIVU  = 3'b100;
    localparam logic [2:0] MD_MFHI  = 3'b101;
    localparam logic [2:0] MD_MFLO  = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DIV  = 2'b10
    } md_state_e;

    // True for every op that must wait while the multiply/divide unit is busy
    function automatic logic md_uses_unit(input logic [2:0] op);
        logic uses;
        case (op)
            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MFHI, MD_MFLO: uses = 1'b1;
            default:                                             uses = 1'b0;
        endcase
        return uses;
    endfunction

endpackage

// File: rtl/execute_stage_md.sv
// Iterative multiply/divide unit with HI/LO: fixed-latency multiply and a
// one-bit-per-cycle restoring divider working on operand magnitudes.
module md_unit
    import execute_stage_pkg::*;
#(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [2:0]  MdOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int CNT_W = 8;

    md_state_e        state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [31:0]      a_r, a_s, b_r, b_s;
    logic             sgn_r, sgn_s;
    logic [31:0]      rem_r, rem_s, quo_r, quo_s, dvs_r, dvs_s;
    logic [31:0]      hi_r, hi_s, lo_r, lo_s;
    logic [63:0]      step_s;
    logic             div_sgn_s;

    function automatic logic [63:0] mul64(input logic [31:0] x, input logic [31:0] y,
                                          input logic sgn);
        logic [63:0] xe;
        logic [63:0] ye;
        xe = {{32{sgn & x[31]}}, x};
        ye = {{32{sgn & y[31]}}, y};
        return xe * ye;
    endfunction

    function automatic logic [31:0] mag32(input logic [31:0] v, input logic sgn);
        logic [31:0] m;
        if (sgn && v[31]) m = 32'd0 - v;
        else              m = v;
        return m;
    endfunction

    // One restoring step: returns {remainder, quotient-shift-register}
    function automatic logic [63:0] div_step(input logic [31:0] rem, input logic [31:0] quo,
                                             input logic [31:0] dvs);
        logic [32:0] sh;
        logic [32:0] diff;
        logic [63:0] res;
        sh   = {rem, quo[31]};
        diff = sh - {1'b0, dvs};
        if (!diff[32]) res = {diff[31:0], quo[30:0], 1'b1};
        else           res = {sh[31:0],   quo[30:0], 1'b0};
        return res;
    endfunction

    assign busy = (state_r != ST_IDLE);
    assign HI   = hi_r;
    assign LO   = lo_r;
    assign div_sgn_s = (MdOp == MD_DIV);

    // Next-state, operand latch, iteration and HI/LO write logic
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        a_s     = a_r;
        b_s     = b_r;
        sgn_s   = sgn_r;
        rem_s   = rem_r;
        quo_s   = quo_r;
        dvs_s   = dvs_r;
        hi_s    = hi_r;
        lo_s    = lo_r;
        step_s  = 64'd0;
        case (state_r)
            ST_IDLE: begin
                if (MdOp == MD_MULT || MdOp == MD_MULTU) begin
                    a_s   = A;
                    b_s   = B;
                    sgn_s = (MdOp == MD_MULT);
                    if (MUL_CYCLES <= 1) begin
                        {hi_s, lo_s} = mul64(A, B, MdOp == MD_MULT);
                        cnt_s        = {CNT_W{1'b0}};
                    end else begin
                        state_s = ST_MUL;
                        cnt_s   = CNT_W'(MUL_CYCLES - 1);
                    end
                end else if (MdOp == MD_DIV || MdOp == MD_DIVU) begin
                    // The start cycle already produces the first quotient bit
                    a_s     = A;
                    b_s     = B;
                    sgn_s   = div_sgn_s;
                    dvs_s   = mag32(B, div_sgn_s);
                    step_s  = div_step(32'd0, mag32(A, div_sgn_s), mag32(B, div_sgn_s));
                    rem_s   = step_s[63:32];
                    quo_s   = step_s[31:0];
                    state_s = ST_DIV;
                    cnt_s   = CNT_W'(DIV_CYCLES - 1);
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_MUL: begin
                if (cnt_r <= CNT_W'(1)) begin
                    {hi_s, lo_s} = mul64(a_r, b_r, sgn_r);
                    state_s      = ST_IDLE;
                    cnt_s        = {CNT_W{1'b0}};
                end else begin
                    cnt_s = cnt_r - CNT_W'(1);
                end
            end
            ST_DIV: begin
                step_s = div_step(rem_r, quo_r, dvs_r);
                rem_s  = step_s[63:32];
                quo_s  = step_s[31:0];
                if (cnt_r <= CNT_W'(1)) begin
                    state_s = ST_IDLE;
                    cnt_s   = {CNT_W{1'b0}};
                    if (b_r == 32'd0) begin
                        lo_s = 32'hFFFF_FFFF;
                        hi_s = a_r;
                    end else begin
                        lo_s = (sgn_r && (a_r[31] ^ b_r[31])) ? 32'd0 - step_s[31:0] : step_s[31:0];
                        hi_s = (sgn_r && a_r[31]) ? 32'd0 - step_s[63:32] : step_s[63:32];
                    end
                end else begin
                    cnt_s = cnt_r - CNT_W'(1);
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // State register; reset abandons any operation in flight
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            a_r     <= 32'd0;
            b_r     <= 32'd0;
            sgn_r   <= 1'b0;
            rem_r   <= 32'd0;
            quo_r   <= 32'd0;
            dvs_r   <= 32'd0;
            hi_r    <= 32'd0;
            lo_r    <= 32'd0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            a_r     <= a_s;
            b_r     <= b_s;
            sgn_r   <= sgn_s;
            rem_r   <= rem_s;
            quo_r   <= quo_s;
            dvs_r   <= dvs_s;
            hi_r    <= hi_s;
            lo_r    <= lo_s;
        end
    end

endmodule

// File: rtl/execute_stage.sv
// EX stage of the 5-stage MIPS pipeline: ALU, destination select, mul/div
// unit interlock and the EX/MEM pipeline register.
module execute_stage
    import execute_stage_pkg::*;
#(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        RegWriteE,
    input  logic        MemToRegE,
    input  logic        MemWriteE,
    input  logic        ALUSrcE,
    input  logic        RegDstE,
    input  logic [3:0]  ALUControlE,
    input  logic [2:0]  MdOpE,
    input  logic [31:0] SrcAE,
    input  logic [31:0] RtDataE,
    input  logic [31:0] SignImmE,
    input  logic [4:0]  RtE,
    input  logic [4:0]  RdE,
    output logic        StallE,
    output logic        RegWriteM,
    output logic        MemToRegM,
    output logic        MemWriteM,
    output logic [4:0]  WriteRegM,
    output logic [31:0] WriteDataM,
    output logic [31:0] ALUresultM
);

    logic        md_busy_s;
    logic        stall_s;
    logic [31:0] hi_s, lo_s;
    logic [31:0] src_b_s, alu_out_s, result_s;
    logic [4:0]  write_reg_s;

    md_unit #(
        .MUL_CYCLES(MUL_CYCLES),
        .DIV_CYCLES(DIV_CYCLES)
    ) u_md (
        .CLK  (CLK),
        .RST_N(RST_N),
        .MdOp (MdOpE),
        .A    (SrcAE),
        .B    (RtDataE),
        .busy (md_busy_s),
        .HI   (hi_s),
        .LO   (lo_s)
    );

    assign stall_s     = md_busy_s && md_uses_unit(MdOpE);
    assign StallE      = stall_s;
    assign src_b_s     = ALUSrcE ? SignImmE : RtDataE;
    assign write_reg_s = RegDstE ? RdE : RtE;

    // ALU; unassigned codes produce zero
    always_comb begin
        alu_out_s = 32'd0;
        case (ALUControlE)
            ALU_AND:  alu_out_s = SrcAE & src_b_s;
            ALU_OR:   alu_out_s = SrcAE | src_b_s;
            ALU_ADD:  alu_out_s = SrcAE + src_b_s;
            ALU_XOR:  alu_out_s = SrcAE ^ src_b_s;
            ALU_SUB:  alu_out_s = SrcAE - src_b_s;
            ALU_SLT:  alu_out_s = {31'd0, ($signed(SrcAE) < $signed(src_b_s))};
            ALU_SLTU: alu_out_s = {31'd0, (SrcAE < src_b_s)};
            ALU_LUI:  alu_out_s = {src_b_s[15:0], 16'd0};
            ALU_NOR:  alu_out_s = ~(SrcAE | src_b_s);
            default:  alu_out_s = 32'd0;
        endcase
    end

    // Result source: HI/LO moves bypass the ALU
    always_comb begin
        result_s = alu_out_s;
        case (MdOpE)
            MD_MFHI: result_s = hi_s;
            MD_MFLO: result_s = lo_s;
            default: result_s = alu_out_s;
        endcase
    end

    // EX/MEM register; a stall inserts a bubble and holds the data fields
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            RegWriteM  <= 1'b0;
            MemToRegM  <= 1'b0;
            MemWriteM  <= 1'b0;
            WriteRegM  <= 5'd0;
            WriteDataM <= 32'd0;
            ALUresultM <= 32'd0;
        end else if (stall_s) begin
            RegWriteM  <= 1'b0;
            MemToRegM  <= 1'b0;
            MemWriteM  <= 1'b0;
        end else begin
            RegWriteM  <= RegWriteE;
            MemToRegM  <= MemToRegE;
            MemWriteM  <= MemWriteE;
            WriteRegM  <= write_reg_s;
            WriteDataM <= RtDataE;
            ALUresultM <= result_s;
        end
    end

endmodule
